// File: rtl/mtm_alu_pkg.sv
// Shared constants, payload types and check functions for the mtm_Alu serial link.
// Used by the serializer, the deserializer and the testbench.
package mtm_alu_pkg;

    localparam int unsigned FRAME_BITS  = 11;
    localparam logic        TYPE_DATA   = 1'b0;
    localparam logic        TYPE_CTL    = 1'b1;
    localparam int unsigned RES_BYTES   = 4;
    localparam int unsigned CRC_IN_BITS = 37;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } alu_flags_t;

    // Error flags are sent twice for redundancy.
    typedef struct packed {
        logic err_data;
        logic err_crc;
        logic err_op;
        logic err_data_dup;
        logic err_crc_dup;
        logic err_op_dup;
    } err_flags_t;

    // CRC3, polynomial x^3+x+1, init 0, MSB first.
    function automatic logic [2:0] crc3(input logic [CRC_IN_BITS-1:0] d);
        logic [2:0] c;
        logic       fb;
        c = 3'b000;
        for (int i = CRC_IN_BITS - 1; i >= 0; i--) begin
            fb = c[2] ^ d[i];
            c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
        end
        return c;
    endfunction

    // Bit that makes {d, p} even parity.
    function automatic logic even_par(input logic [6:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// Upstream handshake and serial output bundle of the mtm_Alu transmit side.
interface mtm_alu_serializer_if import mtm_alu_pkg::*; ;

    logic        res_valid;
    logic [31:0] res_data;
    alu_flags_t  res_flags;
    logic        err_valid;
    err_flags_t  err_flags;
    logic        ready;
    logic        busy;
    logic        sout;

    modport master (
        output res_valid, res_data, res_flags, err_valid, err_flags,
        input  ready, busy, sout
    );

    modport slave (
        input  res_valid, res_data, res_flags, err_valid, err_flags,
        output ready, busy, sout
    );

endinterface

// File: rtl/mtm_alu_tx_frame.sv
// 11-bit frame shifter: start, type, 8 payload bits MSB first, stop; each bit held BIT_CYCLES clocks.
module mtm_alu_tx_frame import mtm_alu_pkg::*; #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       type_bit,
    input  logic [7:0] payload,
    output logic       sout,
    output logic       frame_done_c
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned BW = $clog2(FRAME_BITS);

    logic [FRAME_BITS-1:0] sr;
    logic [CW-1:0]         cyc_cnt;
    logic [BW-1:0]         bit_cnt;
    logic                  active;
    logic                  bit_end_c;

    assign bit_end_c    = active && (cyc_cnt == CW'(BIT_CYCLES - 1));
    assign frame_done_c = bit_end_c && (bit_cnt == BW'(FRAME_BITS - 1));
    assign sout         = sr[FRAME_BITS-1];

    // Shifting in ones leaves the line idle-high once the stop bit has gone out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '1;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            active  <= 1'b0;
        end else if (load) begin
            sr      <= {1'b0, type_bit, payload, 1'b1};
            cyc_cnt <= '0;
            bit_cnt <= '0;
            active  <= 1'b1;
        end else if (active) begin
            if (bit_end_c) begin
                cyc_cnt <= '0;
                sr      <= {sr[FRAME_BITS-2:0], 1'b1};
                if (frame_done_c) begin
                    active  <= 1'b0;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end else begin
                cyc_cnt <= cyc_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mtm_alu_serializer.sv
// mtm_Alu transmit side: sends a 5-frame result packet or a 1-frame error packet on sout.
module mtm_alu_serializer import mtm_alu_pkg::*; #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mtm_alu_serializer_if.slave   bus
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_n;
    logic [2:0]  byte_cnt, byte_cnt_n;
    logic        is_err, is_err_n;
    logic [31:0] pkt, pkt_n;
    logic        ready_n, busy_n;
    logic        accept_c, load_c, type_c, frame_done_c;
    logic [7:0]  payload_c, err_byte_c, ctl_byte_c;

    assign accept_c   = bus.ready && (bus.res_valid || bus.err_valid);
    assign err_byte_c = {1'b1, bus.err_flags, even_par({1'b1, bus.err_flags})};
    assign ctl_byte_c = {1'b0, bus.res_flags, crc3({bus.res_data, 1'b0, bus.res_flags})};

    // Packet sequencing; pkt holds the bytes still to be framed.
    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        is_err_n   = is_err;
        pkt_n      = pkt;
        load_c     = 1'b0;
        type_c     = TYPE_DATA;
        payload_c  = pkt[31:24];
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_n    = SHIFT;
                    load_c     = 1'b1;
                    byte_cnt_n = 3'd0;
                    is_err_n   = bus.err_valid;
                    if (bus.err_valid) begin
                        type_c    = TYPE_CTL;
                        payload_c = err_byte_c;
                        pkt_n     = '0;
                    end else begin
                        payload_c = bus.res_data[31:24];
                        pkt_n     = {bus.res_data[23:0], ctl_byte_c};
                    end
                end
            end
            SHIFT: begin
                if (frame_done_c) begin
                    if (is_err || byte_cnt == 3'(RES_BYTES)) begin
                        state_n = IDLE;
                    end else begin
                        load_c     = 1'b1;
                        byte_cnt_n = byte_cnt + 3'd1;
                        pkt_n      = {pkt[23:0], 8'h00};
                        type_c     = (byte_cnt_n == 3'(RES_BYTES)) ? TYPE_CTL : TYPE_DATA;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == IDLE);
        busy_n  = (state_n == SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= 3'd0;
            is_err    <= 1'b0;
            pkt       <= '0;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
        end else begin
            state     <= state_n;
            byte_cnt  <= byte_cnt_n;
            is_err    <= is_err_n;
            pkt       <= pkt_n;
            bus.ready <= ready_n;
            bus.busy  <= busy_n;
        end
    end

    mtm_alu_tx_frame #(.BIT_CYCLES(BIT_CYCLES)) u_frame (
        .clk          (clk),
        .rst          (rst),
        .load         (load_c),
        .type_bit     (type_c),
        .payload      (payload_c),
        .sout         (bus.sout),
        .frame_done_c (frame_done_c)
    );

endmodule
